// File: rtl/seq_divider_8x4.sv
// Iterative restoring divider: N_WIDTH-bit dividend by D_WIDTH-bit divisor, one
// quotient bit per clock, with a start/busy/done handshake and a divide-by-zero flag.
module seq_divider_8x4 #(
   parameter int N_WIDTH = 8,
   parameter int D_WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [N_WIDTH-1:0] N,
   input  logic [D_WIDTH-1:0] D,
   output logic [N_WIDTH-1:0] Q,
   output logic [D_WIDTH-1:0] Rem,
   output logic               busy,
   output logic               done,
   output logic               dz
);

   localparam int CW = (N_WIDTH > 1) ? $clog2(N_WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(N_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q;
   logic [N_WIDTH-1:0] dvd_q;   // dividend shifts out of the MSB, quotient bits enter the LSB
   logic [D_WIDTH-1:0] d_q;
   logic [D_WIDTH:0]   r_q;
   logic [CW-1:0]      cnt_q;
   logic [N_WIDTH-1:0] q_q;
   logic [D_WIDTH-1:0] rem_q;
   logic               busy_q;
   logic               done_q;
   logic               dz_q;

   logic [D_WIDTH:0]   p_w;
   logic               ge_w;
   logic [D_WIDTH:0]   r_d;
   logic [N_WIDTH-1:0] dvd_d;

   always_comb begin
      p_w   = {r_q[D_WIDTH-1:0], dvd_q[N_WIDTH-1]};
      ge_w  = (p_w >= {1'b0, d_q});
      r_d   = ge_w ? (p_w - {1'b0, d_q}) : p_w;
      dvd_d = {dvd_q[N_WIDTH-2:0], ge_w};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         dvd_q   <= '0;
         d_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               busy_q <= 1'b0;
               done_q <= 1'b0;
               if (start) begin
                  if (D != '0) begin
                     dvd_q   <= N;
                     d_q     <= D;
                     r_q     <= '0;
                     cnt_q   <= '0;
                     dz_q    <= 1'b0;
                     busy_q  <= 1'b1;
                     state_q <= RUN;
                  end else begin
                     q_q     <= '1;
                     rem_q   <= '0;
                     dz_q    <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            RUN: begin
               dvd_q <= dvd_d;
               r_q   <= r_d;
               cnt_q <= cnt_q + 1'b1;
               // Results are published only on the final step so Q/Rem stay stable during RUN.
               if (cnt_q == LAST) begin
                  q_q     <= dvd_d;
                  rem_q   <= r_d[D_WIDTH-1:0];
                  dz_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign Q    = q_q;
   assign Rem  = rem_q;
   assign busy = busy_q;
   assign done = done_q;
   assign dz   = dz_q;

endmodule

// File: tb/tb_seq_divider_8x4.sv
// Bench for seq_divider_8x4: directed vector table, hand-built handshake/reset
// sequences, and a randomized back-to-back run against an arithmetic reference.
module tb_seq_divider_8x4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] N = '0;
   logic [3:0] D = '0;
   logic [7:0] Q;
   logic [3:0] Rem;
   logic       busy;
   logic       done;
   logic       dz;

   seq_divider_8x4 dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .N    (N),
      .D    (D),
      .Q    (Q),
      .Rem  (Rem),
      .busy (busy),
      .done (done),
      .dz   (dz)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] n;
      logic [3:0] d;
      int         q;
      int         r;
      int         z;
      int         lat;
      int         busy_cyc;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Issues one single-cycle start, scrambles N/D after the sampling edge, and
   // returns at the negedge where done is high (lat = -1 if it never came).
   task automatic run_op(input logic [7:0] n, input logic [3:0] d,
                         output int lat, output int busy_cyc, output int q_moved);
      logic [7:0] q0;
      @(negedge clk);
      q0    = Q;
      start = 1'b1;
      N     = n;
      D     = d;
      @(posedge clk);
      #1;
      start    = 1'b0;
      N        = ~n;
      D        = ~d;
      lat      = 1;
      busy_cyc = 0;
      q_moved  = 0;
      @(negedge clk);
      while (!done && lat < 20) begin
         if (busy) busy_cyc++;
         if (Q != q0) q_moved = 1;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      if (!done) lat = -1;
   endtask

   initial begin
      int lat, bc, qm, dones, qc, rc, last_done, waited;
      logic [7:0] nq[$];
      logic [3:0] dq[$];
      logic [7:0] en;
      logic [3:0] ed;

      vecs[0] = '{8'd143, 4'd11, 13,  0, 0, 9, 8};
      vecs[1] = '{8'd200, 4'd7,  28,  4, 0, 9, 8};
      vecs[2] = '{8'd5,   4'd9,  0,   5, 0, 9, 8};
      vecs[3] = '{8'd255, 4'd1,  255, 0, 0, 9, 8};
      vecs[4] = '{8'd77,  4'd0,  255, 0, 1, 1, 0};
      vecs[5] = '{8'd77,  4'd3,  25,  2, 0, 9, 8};

      // reset state
      #1;
      check("rst_Q", int'(Q), 0);
      check("rst_Rem", int'(Rem), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_dz", int'(dz), 0);
      @(negedge clk);
      rst = 1'b0;

      // directed vectors
      for (int i = 0; i < 6; i++) begin
         run_op(vecs[i].n, vecs[i].d, lat, bc, qm);
         $display("vec %0d: N=%0d D=%0d -> Q=%0d Rem=%0d dz=%0d lat=%0d", i,
                  vecs[i].n, vecs[i].d, Q, Rem, dz, lat);
         check($sformatf("v%0d_Q", i), int'(Q), vecs[i].q);
         check($sformatf("v%0d_Rem", i), int'(Rem), vecs[i].r);
         check($sformatf("v%0d_dz", i), int'(dz), vecs[i].z);
         check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         check($sformatf("v%0d_busy_cycles", i), bc, vecs[i].busy_cyc);
         check($sformatf("v%0d_Q_moved_in_run", i), qm, 0);
         @(negedge clk);
         check($sformatf("v%0d_done_one_cycle", i), int'(done), 0);
      end

      // start re-asserted mid-operation with new operands must be ignored
      @(negedge clk);
      start = 1'b1;
      N = 8'd9;
      D = 4'd2;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      N = 8'd100;
      D = 4'd10;
      @(posedge clk);
      #1 start = 1'b0;
      dones = 0;
      qc = -1;
      rc = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done) begin
            dones++;
            qc = int'(Q);
            rc = int'(Rem);
         end
      end
      $display("ignore-start: N=9 D=2 -> Q=%0d Rem=%0d dones=%0d", qc, rc, dones);
      check("ign_done_count", dones, 1);
      check("ign_Q", qc, 4);
      check("ign_Rem", rc, 1);

      // asynchronous reset in the middle of RUN
      @(negedge clk);
      start = 1'b1;
      N = 8'd200;
      D = 4'd7;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      $display("async reset mid-run: Q=%0d Rem=%0d busy=%0d done=%0d dz=%0d", Q, Rem, busy, done, dz);
      check("arst_Q", int'(Q), 0);
      check("arst_Rem", int'(Rem), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_done", int'(done), 0);
      check("arst_dz", int'(dz), 0);
      @(negedge clk);
      rst = 1'b0;
      run_op(8'd60, 4'd15, lat, bc, qm);
      $display("after reset: N=60 D=15 -> Q=%0d Rem=%0d lat=%0d", Q, Rem, lat);
      check("post_rst_Q", int'(Q), 4);
      check("post_rst_Rem", int'(Rem), 0);
      check("post_rst_latency", lat, 9);

      // randomized back-to-back with start held high
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      N = 8'($urandom);
      D = 4'($urandom_range(1, 15));
      nq.push_back(N);
      dq.push_back(D);
      last_done = -1;
      for (int i = 0; i < 1000; i++) begin
         waited = 0;
         @(negedge clk);
         while (!done && waited < 30) begin
            @(negedge clk);
            waited++;
         end
         if (!done) begin
            check("rand_timeout", 0, 1);
            break;
         end
         en = nq.pop_front();
         ed = dq.pop_front();
         $display("rand %0d: N=%0d D=%0d -> Q=%0d Rem=%0d dz=%0d", i, en, ed, Q, Rem, dz);
         check("rand_Q", int'(Q), int'(en) / int'(ed));
         check("rand_Rem", int'(Rem), int'(en) % int'(ed));
         check("rand_invariant", int'(Q) * int'(ed) + int'(Rem), int'(en));
         check("rand_rem_lt_d", int'(Rem < ed), 1);
         check("rand_dz", int'(dz), 0);
         if (last_done >= 0) check("rand_spacing", cyc - last_done, 10);
         last_done = cyc;
         if (i < 999) begin
            N = 8'($urandom);
            D = 4'($urandom_range(1, 15));
            nq.push_back(N);
            dq.push_back(D);
         end else begin
            start = 1'b0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
